// File: rtl/hazard_unit.sv
// Consumer-side hazard controller: load-use / branch-operand stalls, MDU full hold, taken-branch flush.
// Optional perf counters (StallCycles, FlushCount) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit #(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IF_ID_rs,
  input  logic [4:0] IF_ID_rt,
  input  logic       IF_ID_UseRt,
  input  logic       IF_ID_Branch,
  input  logic       BranchTaken,
  input  logic [4:0] ID_EX_rt,
  input  logic [4:0] ID_EX_rd,
  input  logic       ID_EX_RegDst,
  input  logic       ID_EX_MemRead,
  input  logic       ID_EX_RegWrite,
  input  logic [4:0] EX_MEM_rd,
  input  logic       EX_MEM_MemRead,
  input  logic       MduStart,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       ID_EX_Write,
  output logic       ID_EX_Flush,
  output logic       IF_ID_Flush,
  output logic       EX_MEM_Flush,
  output logic       Busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  typedef enum logic [1:0] {RUN, STALL1, MDU_WAIT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MDU_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] ex_dst;
  logic       ex_hit, mem_hit;
  logic       load_use, br_alu, br_load, br_mem;
  logic       fe_stall, full_hold, br_flush;

  assign ex_dst  = ID_EX_RegDst ? ID_EX_rd : ID_EX_rt;
  assign ex_hit  = (ex_dst != 5'd0) &&
                   ((ex_dst == IF_ID_rs) || (IF_ID_UseRt && (ex_dst == IF_ID_rt)));
  assign mem_hit = (EX_MEM_rd != 5'd0) &&
                   ((EX_MEM_rd == IF_ID_rs) || (IF_ID_UseRt && (EX_MEM_rd == IF_ID_rt)));

  assign load_use = ID_EX_MemRead & ex_hit;
  assign br_alu   = IF_ID_Branch & ID_EX_RegWrite & ~ID_EX_MemRead & ex_hit;
  assign br_load  = IF_ID_Branch & ID_EX_MemRead & ex_hit;
  assign br_mem   = IF_ID_Branch & EX_MEM_MemRead & mem_hit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fe_stall  = 1'b0;
    full_hold = 1'b0;
    br_flush  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (MduStart) begin
          state_d   = MDU_WAIT;
          cnt_d     = CNT_INIT;
          full_hold = 1'b1;
        end else if (br_load) begin
          fe_stall = 1'b1;
          state_d  = STALL1;
        end else if (load_use | br_alu | br_mem) begin
          fe_stall = 1'b1;
        end else if (IF_ID_Branch & BranchTaken) begin
          br_flush = 1'b1;
        end
      end
      STALL1: begin
        fe_stall = 1'b1;
        state_d  = RUN;
      end
      MDU_WAIT: begin
        // Leave as cnt reaches 0 so the hold spans exactly MDU_LAT cycles including the start cycle.
        full_hold = 1'b1;
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Reset forces defaults even though hazard inputs may still be live.
  assign PC_Write     = rst | ~(fe_stall | full_hold);
  assign IF_ID_Write  = rst | ~(fe_stall | full_hold);
  assign ID_EX_Write  = rst | ~full_hold;
  assign ID_EX_Flush  = ~rst & fe_stall;
  assign IF_ID_Flush  = ~rst & br_flush;
  assign EX_MEM_Flush = ~rst & full_hold;
  assign Busy         = (state_q != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!PC_Write && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (IF_ID_Flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed test-plan steps followed by randomized cycles checked against a behavioural model.
module tb_hazard_unit;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rt, ID_EX_rd, EX_MEM_rd;
  logic       IF_ID_UseRt, IF_ID_Branch, BranchTaken;
  logic       ID_EX_RegDst, ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead, MduStart;
  logic       PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Flush, IF_ID_Flush, EX_MEM_Flush, Busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  int tests = 0;
  int fails = 0;

  // Model state: remaining MDU wait cycles, pending second branch bubble, perf totals.
  int m_hold  = 0;
  bit m_extra = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_unit #(.MDU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_UseRt(IF_ID_UseRt),
    .IF_ID_Branch(IF_ID_Branch), .BranchTaken(BranchTaken),
    .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd), .ID_EX_RegDst(ID_EX_RegDst),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_MemRead(EX_MEM_MemRead), .MduStart(MduStart),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .ID_EX_Flush(ID_EX_Flush), .IF_ID_Flush(IF_ID_Flush), .EX_MEM_Flush(EX_MEM_Flush),
    .Busy(Busy)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
  );

  always #5 clk = ~clk;

  // {PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Flush, IF_ID_Flush, EX_MEM_Flush, Busy}
  localparam logic [6:0] DEF   = 7'b1110000;
  localparam logic [6:0] FE    = 7'b0011000;
  localparam logic [6:0] FE_B  = 7'b0011001;
  localparam logic [6:0] FLUSH = 7'b1110100;
  localparam logic [6:0] HOLD0 = 7'b0000010;
  localparam logic [6:0] HOLD  = 7'b0000011;

  function automatic logic [6:0] obs();
    return {PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Flush, IF_ID_Flush, EX_MEM_Flush, Busy};
  endfunction

  function automatic bit hit(logic [4:0] d, logic [4:0] r);
    return (d != 5'd0) && (d == r);
  endfunction

  task automatic clear_in();
    IF_ID_rs = 0; IF_ID_rt = 0; ID_EX_rt = 0; ID_EX_rd = 0; EX_MEM_rd = 0;
    IF_ID_UseRt = 0; IF_ID_Branch = 0; BranchTaken = 0; ID_EX_RegDst = 0;
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; EX_MEM_MemRead = 0; MduStart = 0;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] o;
    o = obs();
    tests++;
    assert (o === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  // Check current cycle's outputs, then advance to the next negedge.
  task automatic dstep(input string tag, input logic [6:0] exp);
    #1 chk(tag, exp);
    @(posedge clk); @(negedge clk);
  endtask

  // One randomized cycle: outputs derived from the hazard rules, not from FSM state names.
  task automatic rstep(input int n);
    logic [6:0] exp;
    logic [4:0] dst;
    bit ex_h, mem_h, lu, bra, brl, brm, busy;
    rst            = ($urandom_range(0, 59) == 0);
    IF_ID_rs       = 5'($urandom_range(0, 3));
    IF_ID_rt       = 5'($urandom_range(0, 3));
    ID_EX_rt       = 5'($urandom_range(0, 3));
    ID_EX_rd       = 5'($urandom_range(0, 3));
    EX_MEM_rd      = 5'($urandom_range(0, 3));
    IF_ID_UseRt    = 1'($urandom_range(0, 1));
    IF_ID_Branch   = 1'($urandom_range(0, 1));
    BranchTaken    = 1'($urandom_range(0, 1));
    ID_EX_RegDst   = 1'($urandom_range(0, 1));
    ID_EX_MemRead  = ($urandom_range(0, 9) < 3);
    ID_EX_RegWrite = 1'($urandom_range(0, 1));
    EX_MEM_MemRead = ($urandom_range(0, 9) < 3);
    MduStart       = ($urandom_range(0, 9) == 0);
    #1;
    dst   = ID_EX_RegDst ? ID_EX_rd : ID_EX_rt;
    ex_h  = hit(dst, IF_ID_rs) || (IF_ID_UseRt && hit(dst, IF_ID_rt));
    mem_h = hit(EX_MEM_rd, IF_ID_rs) || (IF_ID_UseRt && hit(EX_MEM_rd, IF_ID_rt));
    lu    = ID_EX_MemRead && ex_h;
    bra   = IF_ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && ex_h;
    brl   = IF_ID_Branch && ID_EX_MemRead && ex_h;
    brm   = IF_ID_Branch && EX_MEM_MemRead && mem_h;
    if (rst) begin
      m_hold = 0; m_extra = 0; m_stall = 0; m_flush = 0;
    end
    busy = (m_hold > 0) || m_extra;
`ifdef HAZARD_PERF_CNT_EN
    tests++;
    assert (StallCycles === 32'(m_stall) && FlushCount === 32'(m_flush)) else begin
      fails++;
      $error("FAIL perf[%0d] observed=%0d/%0d expected=%0d/%0d", n, StallCycles, FlushCount, m_stall, m_flush);
    end
`endif
    if (rst)             exp = DEF;
    else if (m_hold > 0) begin exp = HOLD; m_hold--; end
    else if (m_extra)    begin exp = FE_B; m_extra = 0; end
    else if (MduStart)   begin exp = HOLD0; m_hold = LAT - 1; end
    else if (brl)        begin exp = FE; m_extra = 1; end
    else if (lu || bra || brm) exp = FE;
    else if (IF_ID_Branch && BranchTaken) exp = FLUSH;
    else exp = DEF;
    exp[0] = busy;
    if (!rst && !exp[6]) m_stall++;
    if (!rst && exp[2]) m_flush++;
    chk($sformatf("rand[%0d]", n), exp);
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    @(negedge clk);
    // Live load-use inputs while in reset must not leak through.
    ID_EX_MemRead = 1; ID_EX_rt = 5; IF_ID_rs = 5;
    dst_reset: dstep("reset_defaults", DEF);
    clear_in(); rst = 1'b0;
    dstep("idle", DEF);

    ID_EX_MemRead = 1; ID_EX_rt = 5; IF_ID_rs = 5;
    dstep("load_use", FE);
    clear_in();
    dstep("load_use_after", DEF);

    ID_EX_MemRead = 1; ID_EX_rt = 0; IF_ID_rs = 0;
    dstep("reg0_no_stall", DEF);
    ID_EX_rt = 5; IF_ID_rs = 1; IF_ID_rt = 5; IF_ID_UseRt = 0;
    dstep("rt_unused", DEF);
    IF_ID_UseRt = 1;
    dstep("rt_used", FE);
    clear_in();

    IF_ID_Branch = 1; ID_EX_MemRead = 1; ID_EX_rt = 8; IF_ID_rs = 8; BranchTaken = 1;
    dstep("br_load_1", FE);
    ID_EX_MemRead = 0; ID_EX_rt = 0;
    dstep("br_load_2", FE_B);
    dstep("br_taken", FLUSH);
    clear_in();
    dstep("br_taken_after", DEF);

    IF_ID_Branch = 1; ID_EX_RegWrite = 1; ID_EX_RegDst = 1; ID_EX_rd = 9; IF_ID_rs = 9;
    dstep("br_alu", FE);
    clear_in();
    IF_ID_Branch = 1; EX_MEM_MemRead = 1; EX_MEM_rd = 7; IF_ID_rt = 7; IF_ID_UseRt = 1;
    dstep("br_mem", FE);
    clear_in();

    // MDU start coinciding with a load-use: hold wins, later starts are ignored.
    MduStart = 1; ID_EX_MemRead = 1; ID_EX_rt = 3; IF_ID_rs = 3;
    dstep("mdu_start", HOLD0);
    clear_in(); MduStart = 1;
    dstep("mdu_w1", HOLD);
    dstep("mdu_w2", HOLD);
    dstep("mdu_w3", HOLD);
    clear_in();
    dstep("mdu_done", DEF);

    MduStart = 1;
    dstep("mdu2_start", HOLD0);
    clear_in();
    dstep("mdu2_w1", HOLD);
    rst = 1'b1;
    ID_EX_MemRead = 1; ID_EX_rt = 4; IF_ID_rs = 4;
    #1 chk("rst_in_mdu", DEF);
`ifdef HAZARD_PERF_CNT_EN
    tests++;
    assert (StallCycles === 32'd0) else begin
      fails++;
      $error("FAIL perf_rst observed=%0d expected=0", StallCycles);
    end
`endif
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    dstep("post_rst_load_use", FE);
    clear_in();
    dstep("post_rst_idle", DEF);

    rst = 1'b1; m_hold = 0; m_extra = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 600; i++) rstep(i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. Forwarding handles values that already exist in EX/MEM or MEM/WB. This block handles the consumer side, where a value does not exist yet. It stalls the front end on load-use and branch-operand hazards, and holds the whole pipeline during multi-cycle multiply/divide. It also flushes IF/ID on taken branches resolved in ID.

## Interface
- MDU_LAT, 4, multiply/divide execute latency in cycles; legal range 2..15
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- IF_ID_rs, IF_ID_rt  in  5  source registers of the instruction in ID
- IF_ID_UseRt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
- IF_ID_Branch  in  1  ID instruction is beq/bne (compared in ID)
- BranchTaken  in  1  ID comparator result; valid only when IF_ID_Branch=1 and not stalling
- ID_EX_rt, ID_EX_rd  in  5  destination candidates of the EX instruction; ID_EX_RegDst selects rd
- ID_EX_RegDst, ID_EX_MemRead, ID_EX_RegWrite  in  1  EX instruction controls
- EX_MEM_rd  in  5  MEM-stage destination
- EX_MEM_MemRead  in  1  MEM instruction is a load
- MduStart  in  1  EX instruction is mult/div; sampled in RUN only
- PC_Write, IF_ID_Write, ID_EX_Write  out  1  stage-register write enables
- ID_EX_Flush, IF_ID_Flush, EX_MEM_Flush  out  1  insert bubble into the named register
- Busy  out  1  state != RUN

## Operation
- EX destination: ID_EX_dst = ID_EX_RegDst ? ID_EX_rd : ID_EX_rt. A destination of register 0 never causes a hazard.
- The hit terms below apply to rs, and also to rt when IF_ID_UseRt=1:
  - LoadUse = ID_EX_MemRead and EX destination hit.
  - BrAlu = IF_ID_Branch and ID_EX_RegWrite and not ID_EX_MemRead and EX destination hit.
  - BrLoad = IF_ID_Branch and ID_EX_MemRead and EX destination hit.
  - BrMem = IF_ID_Branch and EX_MEM_MemRead and EX_MEM_rd hit.
- FSM states: RUN, STALL1, MDU_WAIT. Outputs are Mealy (state plus current inputs).
- RUN, priority order:
  - MduStart: go to MDU_WAIT; cnt <= MDU_LAT-1; full hold applies this cycle.
  - Else BrLoad: front-end stall; go to STALL1.
  - Else LoadUse, BrAlu or BrMem: front-end stall; stay in RUN and re-evaluate next cycle.
  - Else, if IF_ID_Branch and BranchTaken: IF_ID_Flush=1.
- STALL1: unconditional front-end stall for one cycle, then return to RUN. This covers the second bubble a branch needs after a load.
- MDU_WAIT: full hold every cycle. cnt decrements each cycle; when cnt==0, go to RUN. MduStart is ignored while in this state.
- Front-end stall: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. All other outputs keep their default.
- Full hold: PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Flush=1. ID_EX_Flush=0.
- Defaults: PC_Write=IF_ID_Write=ID_EX_Write=1; all flushes 0.
- BranchTaken is ignored in any cycle with a stall or hold.
- cnt is 4 bits. It never wraps: it is only decremented when nonzero.

## Timing
- Reset: state=RUN and cnt=0 immediately. Outputs show their defaults while rst=1.
- Reset asserted mid-stall or mid-MDU_WAIT aborts it immediately. The next cycle is normal RUN.
- Latencies:
  - Load-use costs exactly 1 bubble.
  - Branch after ALU op: 1 bubble.
  - Branch after a load in EX: 2 bubbles (RUN stall, then STALL1).
  - Branch after a load in MEM: 1 bubble.
- MDU hold: PC frozen for exactly MDU_LAT consecutive cycles, counting the MduStart cycle.
- Simultaneous MduStart and LoadUse: the MDU hold wins. LoadUse is re-evaluated when the state returns to RUN.
- Next-state and cnt registers update on the rising clk edge.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs StallCycles[31:0] and FlushCount[31:0].
  - StallCycles increments in every cycle with PC_Write=0.
  - FlushCount increments on each IF_ID_Flush.
  - Both counters saturate at 0xFFFFFFFF and are cleared by rst.
- HAZARD_PERF_CNT_EN undefined: the ports and registers are absent. All other behaviour is identical.

## Test plan
- Load then use: ID_EX_MemRead=1, ID_EX_rt=5, IF_ID_rs=5 -> one cycle with PC_Write=0 and ID_EX_Flush=1; the next cycle has defaults.
- Register-0 and UseRt checks:
  - ID_EX_rt=0 with IF_ID_rs=0 -> no stall.
  - IF_ID_rt match with IF_ID_UseRt=0 -> no stall.
- Branch after load: IF_ID_Branch=1, ID_EX_MemRead=1, ID_EX_rt=IF_ID_rs=8 -> 2 consecutive stall cycles, the second in STALL1; BranchTaken=1 during the stalls gives IF_ID_Flush=0.
- Taken branch with no hazard: BranchTaken=1 -> IF_ID_Flush=1 for 1 cycle; PC_Write=1.
- MDU with MDU_LAT=4: MduStart pulse -> PC_Write=0, ID_EX_Write=0 and EX_MEM_Flush=1 for exactly 4 cycles; Busy=1 for the 3 cycles after the start; a second MduStart during the hold is ignored.
- Reset in MDU_WAIT at cnt=2: outputs return to defaults immediately. With HAZARD_PERF_CNT_EN, StallCycles reads 0 after reset and then counts 1 per stalled cycle.
